step_sequencer_arbiter: RTL

- Shares one 3-state one-hot step ring (S0=001 → S1=010 → S2=100 → S0) among NUM_REQ requesters.
- Each requester asks for a burst of N ring advances. The block arbitrates round-robin, then drives the ring's single-cycle step input (step_out) N times with a programmable gap between steps.
- It keeps a mirrored copy of the ring state and signals completion per burst.
- Sits between client control logic and the step-ring FSM; it is the only driver of the ring's advance input.

---
 rtl/step_sequencer_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/step_sequencer_arbiter.sv
// step_sequencer_arbiter
// Round-robin arbiter that shares one 3-state one-hot step ring among
// NUM_REQ requesters. The winner gets a burst of N single-cycle step pulses,
// with GAP idle cycles between pulses. The block keeps a mirrored copy of the
// ring state and pulses done/done_id when each burst ends.
// Optional feature: define SEQ_ABORT_EN to add the abort input and the
// aborted output, which allow a running burst to be cut short.
module step_sequencer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int GAP     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_W-1:0]     req_steps,
`ifdef SEQ_ABORT_EN
    input  logic                         abort,
    output logic                         aborted,
`endif
    output logic [NUM_REQ-1:0]           grant,
    output logic                         step_out,
    output logic [2:0]                   ring_state,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_REQ)-1:0]   done_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;

    logic [IDX_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [CNT_W-1:0]   w_win_steps;
    logic               w_abort;

`ifdef SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Round-robin pick: the set request at the smallest distance past rr_ptr wins
    always_comb begin
        int best_d;
        int d;
        best_d       = NUM_REQ;
        d            = 0;
        w_winner     = r_rr_ptr;
        w_win_onehot = '0;
        w_win_steps  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - 1 - int'(r_rr_ptr)) % NUM_REQ;
            if (req[i] && (d < best_d)) begin
                best_d          = d;
                w_winner        = IDX_W'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_win_steps = req_steps[i*CNT_W +: CNT_W];
            end
        end
    end

    // Burst sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            grant      <= '0;
            step_out   <= 1'b0;
            ring_state <= 3'b001;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_cnt      <= '0;
            r_gap      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        grant    <= w_win_onehot;
                        r_cnt    <= w_win_steps;
                        r_rr_ptr <= w_winner;
                        busy     <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A zero-length burst skips straight to completion
                    if (r_cnt == '0) begin
                        done    <= 1'b1;
                        done_id <= r_rr_ptr;
                        r_state <= ST_DONE;
                    end else begin
                        step_out <= 1'b1;
                        r_state  <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // The pulse issued this cycle always completes
                    ring_state <= {ring_state[1:0], ring_state[2]};
                    r_cnt      <= r_cnt - 1'b1;
                    if ((r_cnt == CNT_W'(1)) || w_abort) begin
                        step_out <= 1'b0;
                        done     <= 1'b1;
                        done_id  <= r_rr_ptr;
                        r_state  <= ST_DONE;
                    end else if (GAP == 0) begin
                        step_out <= 1'b1;
                    end else begin
                        step_out <= 1'b0;
                        r_gap    <= GAP_W'(GAP);
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_gap <= r_gap - 1'b1;
                    if (w_abort) begin
                        done    <= 1'b1;
                        done_id <= r_rr_ptr;
                        r_state <= ST_DONE;
                    end else if (r_gap == GAP_W'(1)) begin
                        step_out <= 1'b1;
                        r_state  <= ST_STEP;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    grant   <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_ABORT_EN
    // Flag an abort-terminated burst during its DONE cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort && ((r_state == ST_STEP) || (r_state == ST_GAP));
        end
    end
`endif

endmodule
